// File: rtl/az_sample_capture.sv
// az_sample_capture: counts comparator edges during the sequencer's HI and LO
// sample windows and publishes each HI/LO pair to the SPI readout through a
// valid/ack handshake. Flags overrun (pending pair overwritten) and saturation.
//
// Optional feature macro: AZ_SAMPLE_CAPTURE_DIFF_EN
//   defined   -> diff is the registered signed difference hi_count - lo_count
//   undefined -> no subtractor is built and diff is tied to zero
//
// Note: reset_n is an asynchronous, active-HIGH reset despite its name; this
// matches the existing reset net of the surrounding system.

module az_sample_capture #(
  parameter int CNT_W = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    phase_hi,
  input  logic                    phase_lo,
  input  logic                    cmpr_in,
  input  logic                    rd_ack,
  output logic [CNT_W-1:0]        hi_count,
  output logic [CNT_W-1:0]        lo_count,
  output logic signed [CNT_W:0]   diff,
  output logic                    valid,
  output logic                    overrun,
  output logic                    sat,
  output logic [7:0]              seq,
  output logic [7:0]              monitor
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HI_CNT  = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_LO_CNT  = 3'd3,
    ST_PUBLISH = 3'd4
  } state_e;

  // Input conditioning: [0],[1] synchronize cmpr_in, [2] is the edge reference.
  logic [2:0]       cmpr_sync_q, cmpr_sync_d;
  logic             phase_hi_prev_q, phase_hi_prev_d;
  logic             phase_lo_prev_q, phase_lo_prev_d;
  logic             cstb;
  logic             hi_rise, hi_fall, lo_rise, lo_fall;
  logic             both_high;

  // Window FSM and counting datapath.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_tmp_q, hi_tmp_d;
  logic [CNT_W-1:0] lo_tmp_q, lo_tmp_d;
  logic             sat_hi_q, sat_hi_d;
  logic             sat_lo_q, sat_lo_d;
  logic [CNT_W-1:0] cnt_step;
  logic             step_sat;
  logic             publish;

  // Published outputs.
  logic [CNT_W-1:0] hi_count_q, hi_count_d;
  logic [CNT_W-1:0] lo_count_q, lo_count_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             sat_q, sat_d;
  logic [7:0]       seq_q, seq_d;
  logic             ack_hit;

  // Next values for the synchronizer chain and the phase history registers.
  always_comb begin
    cmpr_sync_d     = {cmpr_sync_q[1:0], cmpr_in};
    phase_hi_prev_d = phase_hi;
    phase_lo_prev_d = phase_lo;
  end

  // Edge detection on the synchronized comparator and on both window inputs.
  always_comb begin
    cstb      = cmpr_sync_q[1] & ~cmpr_sync_q[2];
    hi_rise   = phase_hi & ~phase_hi_prev_q;
    hi_fall   = ~phase_hi & phase_hi_prev_q;
    lo_rise   = phase_lo & ~phase_lo_prev_q;
    lo_fall   = ~phase_lo & phase_lo_prev_q;
    both_high = phase_hi & phase_lo;
  end

  // Phase history resets to 1 so a window already open at reset release is not counted.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      cmpr_sync_q     <= '0;
      phase_hi_prev_q <= 1'b1;
      phase_lo_prev_q <= 1'b1;
    end else begin
      cmpr_sync_q     <= cmpr_sync_d;
      phase_hi_prev_q <= phase_hi_prev_d;
      phase_lo_prev_q <= phase_lo_prev_d;
    end
  end

  // Window sequencing: count strobes in HI then LO, latch each window, then publish.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    sat_hi_d = sat_hi_q;
    sat_lo_d = sat_lo_q;
    publish  = 1'b0;
    cnt_step = cnt_q;
    step_sat = 1'b0;

    if (cstb) begin
      if (&cnt_q) begin
        step_sat = 1'b1;
      end else begin
        cnt_step = cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (hi_rise) begin
          cnt_d    = '0;
          sat_hi_d = 1'b0;
          state_d  = ST_HI_CNT;
        end
      end

      ST_HI_CNT: begin
        if (both_high) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d    = cnt_step;
          sat_hi_d = sat_hi_q | step_sat;
          if (hi_fall) begin
            hi_tmp_d = cnt_step;
            state_d  = ST_WAIT_LO;
          end
        end
      end

      ST_WAIT_LO: begin
        if (hi_rise) begin
          cnt_d    = '0;
          hi_tmp_d = '0;
          sat_hi_d = 1'b0;
          state_d  = ST_HI_CNT;
        end else if (lo_rise) begin
          cnt_d    = '0;
          sat_lo_d = 1'b0;
          state_d  = ST_LO_CNT;
        end
      end

      ST_LO_CNT: begin
        if (both_high) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d    = cnt_step;
          sat_lo_d = sat_lo_q | step_sat;
          if (lo_fall) begin
            lo_tmp_d = cnt_step;
            state_d  = ST_PUBLISH;
          end
        end
      end

      ST_PUBLISH: begin
        publish = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, running counter and per-window latches.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
    end
  end

  // Publish/handshake: an ack in the publish cycle consumes the old pair, so no overrun.
  always_comb begin
    hi_count_d = hi_count_q;
    lo_count_d = lo_count_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    sat_d      = sat_q;
    seq_d      = seq_q;
    ack_hit    = rd_ack & valid_q;

    if (publish) begin
      hi_count_d = hi_tmp_q;
      lo_count_d = lo_tmp_q;
      sat_d      = sat_hi_q | sat_lo_q;
      seq_d      = seq_q + 8'd1;
      valid_d    = 1'b1;
      if (ack_hit) begin
        overrun_d = 1'b0;
      end else if (valid_q) begin
        overrun_d = 1'b1;
      end
    end else if (ack_hit) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // Registered readout outputs.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      hi_count_q <= '0;
      lo_count_q <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      sat_q      <= 1'b0;
      seq_q      <= '0;
    end else begin
      hi_count_q <= hi_count_d;
      lo_count_q <= lo_count_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      sat_q      <= sat_d;
      seq_q      <= seq_d;
    end
  end

`ifdef AZ_SAMPLE_CAPTURE_DIFF_EN
  logic signed [CNT_W:0] diff_q, diff_d;

  // Signed HI-LO difference, loaded together with the count pair.
  always_comb begin
    diff_d = diff_q;
    if (publish) begin
      diff_d = $signed({1'b0, hi_tmp_q}) - $signed({1'b0, lo_tmp_q});
    end
  end

  // Difference register.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      diff_q <= '0;
    end else begin
      diff_q <= diff_d;
    end
  end

  assign diff = diff_q;
`else
  assign diff = '0;
`endif

  assign hi_count = hi_count_q;
  assign lo_count = lo_count_q;
  assign valid    = valid_q;
  assign overrun  = overrun_q;
  assign sat      = sat_q;
  assign seq      = seq_q;
  assign monitor  = {2'b00, valid_q, cstb, cmpr_sync_q[1], state_q};

endmodule

// File: doc/az_sample_capture.md
# az_sample_capture

Downstream consumer of the pre-charge/AZ acquisition sequencer. It counts rising edges of the asynchronous ADC comparator/V-to-F output during the sequencer's HI and LO sample windows. It publishes each HI/LO count pair, and optionally their signed difference, to the SPI readout through a valid/ack handshake, and flags overrun and saturation. All logic runs in the `clk` domain; `cmpr_in` is the only asynchronous input.

## Interface
- `CNT_W`, default 24: width of each window counter.
- `clk`: in, 1 bit. System clock, 20 MHz nominal.
- `reset_n`: in, 1 bit. Reset, asynchronous, active-high.
- `phase_hi`: in, 1 bit. Synchronous to `clk`; high for the sequencer's HI sample window.
- `phase_lo`: in, 1 bit. Synchronous to `clk`; high for the LO sample window.
- `cmpr_in`: in, 1 bit. Asynchronous comparator pulse input.
- `rd_ack`: in, 1 bit. Readout acknowledge, one-cycle pulse.
- `hi_count`: out, `CNT_W` bits. Published HI-window edge count.
- `lo_count`: out, `CNT_W` bits. Published LO-window edge count.
- `diff`: out, `CNT_W`+1 bits, signed. Equals `hi_count` − `lo_count`.
- `valid`: out, 1 bit. A published pair is pending.
- `overrun`: out, 1 bit. Sticky; set when a pending pair was overwritten.
- `sat`: out, 1 bit. Published pair contains a saturated counter.
- `seq`: out, 8 bits. Sequence number of the published pair.
- `monitor`: out, 8 bits. Debug: [2:0] state, [3] synced `cmpr_in`, [4] count strobe, [5] `valid`, [7:6] 0.

## Operation
- `cmpr_in` passes through a 2-flop synchronizer, then a rising-edge detector. This gives a 1-cycle strobe `cstb`.
- `phase_hi` and `phase_lo` are edge-detected using previous-value registers. Both registers reset to 1, so a window already high at reset release is never counted.
- FSM states:
  - IDLE: on `phase_hi` rise, clear `cnt`, clear `sat_hi`, go to HI_CNT. A `phase_lo` rise in IDLE is ignored.
  - HI_CNT: each `cstb` adds 1 to `cnt`. On `phase_hi` fall, latch `cnt` into `hi_tmp` and go to WAIT_LO.
  - WAIT_LO: on `phase_lo` rise, clear `cnt` and go to LO_CNT. A `phase_hi` rise here restarts HI_CNT and discards `hi_tmp`.
  - LO_CNT: each `cstb` adds 1 to `cnt`. On `phase_lo` fall, latch into `lo_tmp` and go to PUBLISH.
  - PUBLISH: one cycle. Load the outputs, then go to IDLE.
- If `phase_hi` and `phase_lo` are both high in any counting state, abort to IDLE. Nothing is published and `seq` is unchanged.
- Saturation: `cnt` holds at all-ones and does not wrap. The per-window sat bit is set. `sat` = `sat_hi` OR `sat_lo` of the published pair.
- PUBLISH action:
  - `hi_count` <= `hi_tmp`, `lo_count` <= `lo_tmp`.
  - `seq` <= `seq` + 1, wrapping 255 to 0.
  - `valid` <= 1.
  - If `valid` was already 1 and `rd_ack` is not asserted this cycle, set `overrun` <= 1.
- Handshake:
  - `rd_ack` while `valid`=1 clears `valid` and `overrun` on the next edge.
  - `rd_ack` while `valid`=0 is ignored.
  - `rd_ack` in the same cycle as PUBLISH: the new data is loaded, `valid` stays 1, `overrun` is not set.
- Reset, at any time including mid-window: state IDLE, all counters, temps and outputs 0, `valid`/`overrun`/`sat` 0, `seq` 0.

## Timing
- `cmpr_in` to `cstb`: 3 clk cycles (2 synchronizer flops plus edge register). Minimum countable pulse is 2 clk high and 2 clk low. At 20 MHz the maximum count rate is 5 MHz.
- A window edge on `phase_*` is registered one cycle later. Counting is active from the cycle after the rise is seen through the cycle the fall is seen.
- `cstb` edges up to 3 cycles before the window opens are counted. The same applies at the close. This bias is identical for HI and LO and cancels in `diff`.
- `phase_lo` fall to `valid` high: 2 clk cycles (fall detect, then PUBLISH register).
- All outputs are registered. `diff` updates in the same cycle as `hi_count`/`lo_count`.

## Configuration
- `AZ_SAMPLE_CAPTURE_DIFF_EN`:
  - Defined: `diff` is the registered signed subtraction. It is zero-extended to `CNT_W`+1 bits, then `lo` is subtracted from `hi`, and it is loaded at PUBLISH.
  - Undefined: no subtractor is built and `diff` is constant 0. All other behaviour is identical.

## Test plan
- Normal pair: `phase_hi` high 1000 clk with exactly 50 `cmpr_in` pulses (period 10 clk) placed well inside the window. Then `phase_lo` high 1000 clk with 20 pulses. Required: `hi_count`=50, `lo_count`=20, `diff`=30 (0 with the macro off), `valid`=1 two cycles after the `phase_lo` fall, `seq`=1.
- Overrun: complete two pairs without `rd_ack`. Required: second pair's data visible, `seq`=2, `overrun`=1. A single `rd_ack` clears both `valid` and `overrun`.
- Ack/publish collision: assert `rd_ack` in the PUBLISH cycle while `valid`=1. Required: new data loaded, `valid`=1, `overrun`=0.
- Saturation: `CNT_W`=4, 20 pulses in HI, 3 pulses in LO. Required: `hi_count`=15, `lo_count`=3, `sat`=1, `diff`=12.
- Abort and stray phase: `phase_lo` rise in IDLE is ignored. `phase_hi` and `phase_lo` overlapping during HI_CNT gives no publish and `seq` unchanged. A following normal pair publishes correctly.
- Reset mid-window: assert `reset_n` during HI_CNT with `phase_hi` held high through release. Required: all outputs 0, and no count until the next `phase_hi` rise.
